fetch_unit: RTL and testbench

//   Instruction fetch stage for the RV32I core: owns the program counter.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
//======================================================================
// Module  : fetch_unit
// Brief   : RV32I instruction fetch stage. Owns the PC, issues single
//           outstanding word reads over a valid/ready channel, buffers
//           returned words in a small FIFO and applies redirects.
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        misalign
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;  // nothing outstanding
  localparam logic [1:0] S_WAIT = 2'd1;  // outstanding, response kept
  localparam logic [1:0] S_DROP = 2'd2;  // outstanding, response discarded

  logic [1:0]       state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      req_pc_q, req_pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  // Holds requests off for the first cycle after reset release so that
  // every output is low while reset is asserted.
  logic             run_q;
  logic [31:0]      pc_mem_q   [FIFO_DEPTH];
  logic [31:0]      data_mem_q [FIFO_DEPTH];

  logic outstanding, req_fire, rsp_take, push, pop;

  // Request side outputs and handshake qualifiers, all from registers.
  always_comb begin
    outstanding    = (state_q != S_IDLE);
    imem_req_valid = run_q && !outstanding && (count_q < DEPTH_C);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_take       = imem_rsp_valid && outstanding;
    push           = rsp_take && (state_q == S_WAIT) && !redirect;
    pop            = instr_valid && instr_ready && !redirect;
  end

  // State register and all control/pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      run_q      <= 1'b1;
    end
  end

  // Next-state: a redirect turns any live request into a dropped one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_fire) state_d = redirect ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (rsp_take)      state_d = S_IDLE;
        else if (redirect) state_d = S_DROP;
      end
      S_DROP:  if (rsp_take) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // PC and FIFO bookkeeping; redirect flushes and overrides everything.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    misalign_d = redirect && (redirect_pc[1:0] != 2'b00);
    if (req_fire) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
      data_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  // Head outputs, forced to zero while the buffer is empty.
  always_comb begin
    instr_valid = (count_q != '0);
    instr       = instr_valid ? data_mem_q[rd_ptr_q] : 32'd0;
    instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : 32'd0;
    instr_pc4   = instr_valid ? (pc_mem_q[rd_ptr_q] + 32'd4) : 32'd0;
    op          = instr[6:0];
    funct3      = instr[14:12];
    funct7b5    = instr[30];
    misalign    = misalign_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//======================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit: directed scenarios and
//           a randomized phase against a queue-based reference model.
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n, req_ready, rsp_valid, redirect, instr_ready;
  logic [31:0] rsp_data, redirect_pc;
  logic        req_valid, instr_valid, funct7b5, misalign;
  logic [31:0] req_addr, instr, instr_pc, instr_pc4;
  logic [6:0]  op;
  logic [2:0]  funct3;

  // second instance exercising a wrapping reset PC
  logic        rst2_n, ready2, rsp2_valid;
  logic [31:0] rsp2_data;
  logic        w2_req_valid, w2_instr_valid, w2_f7, w2_mis;
  logic [31:0] w2_req_addr, w2_instr, w2_pc, w2_pc4;
  logic [6:0]  w2_op;
  logic [2:0]  w2_f3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .instr_pc4(instr_pc4), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .misalign(misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .imem_req_valid(w2_req_valid), .imem_req_ready(ready2), .imem_req_addr(w2_req_addr),
    .imem_rsp_valid(rsp2_valid), .imem_rsp_data(rsp2_data),
    .redirect(1'b0), .redirect_pc(32'h0),
    .instr_valid(w2_instr_valid), .instr_ready(1'b0), .instr(w2_instr),
    .instr_pc(w2_pc), .instr_pc4(w2_pc4), .op(w2_op), .funct3(w2_f3),
    .funct7b5(w2_f7), .misalign(w2_mis)
  );

  // ---------------- reference model state ----------------
  logic [31:0] m_fetch_pc, m_req_pc;
  bit          m_run, m_out, m_drop, m_mis, last_hs;
  logic [63:0] m_fifo[$];            // {pc, data}
  // ---------------- memory model ----------------
  bit          mem_pend, mem_fire, spurious_en;
  logic [31:0] mem_addr;
  int          mem_cnt, lat_lo, lat_hi;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0050_0093 ^ (a * 32'h0100_0193);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fetch_pc = 32'h0; m_req_pc = 32'h0;
    m_run = 0; m_out = 0; m_drop = 0; m_mis = 0;
    m_fifo.delete();
  endtask

  function automatic bit exp_req_valid();
    return m_run && !m_out && (m_fifo.size() < DEPTH);
  endfunction

  task automatic check_outputs();
    logic [31:0] ei, ep;
    ei = 32'h0; ep = 32'h0;
    if (m_fifo.size() > 0) begin
      ei = m_fifo[0][31:0];
      ep = m_fifo[0][63:32];
    end
    chk("req_valid", {31'b0, req_valid}, {31'b0, exp_req_valid()});
    chk("req_addr", req_addr, m_fetch_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_fifo.size() > 0});
    chk("instr", instr, ei);
    chk("instr_pc", instr_pc, ep);
    chk("instr_pc4", instr_pc4, (m_fifo.size() > 0) ? ep + 32'd4 : 32'd0);
    chk("op", {25'b0, op}, {25'b0, ei[6:0]});
    chk("funct3", {29'b0, funct3}, {29'b0, ei[14:12]});
    chk("funct7b5", {31'b0, funct7b5}, {31'b0, ei[30]});
    chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_advance();
    bit hs, rsp, pop;
    hs  = rst_n && exp_req_valid() && req_ready;
    rsp = rsp_valid && m_out;
    pop = (m_fifo.size() > 0) && instr_ready;
    last_hs = hs;
    if (mem_fire) mem_pend = 0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (hs) begin
      mem_pend = 1; mem_addr = m_fetch_pc;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
    end
    if (!rst_n) return;
    m_run = 1;
    m_mis = redirect && (redirect_pc[1:0] != 2'b00);
    if (redirect) begin
      m_fifo.delete();
      m_fetch_pc = {redirect_pc[31:2], 2'b00};
      if (rsp) begin m_out = 0; m_drop = 0; end
      else if (m_out || hs) begin m_out = 1; m_drop = 1; end
    end else begin
      if (pop) void'(m_fifo.pop_front());
      if (rsp) begin
        if (!m_drop) m_fifo.push_back({m_req_pc, rsp_data});
        m_out = 0; m_drop = 0;
      end
      if (hs) begin
        m_out = 1; m_req_pc = m_fetch_pc; m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
    req_ready = rdy; instr_ready = irdy; redirect = redir; redirect_pc = rpc;
    mem_fire = mem_pend && (mem_cnt == 0);
    if (mem_fire) begin
      rsp_valid = 1; rsp_data = mem_word(mem_addr);
    end else if (spurious_en && !m_out && !mem_pend && $urandom_range(0, 7) == 0) begin
      rsp_valid = 1; rsp_data = $urandom;
    end else begin
      rsp_valid = 0; rsp_data = $urandom;
    end
    step();
  endtask

  initial begin
    bit found;
    int hold;
    logic [31:0] rpc;
    rst_n = 0; req_ready = 0; rsp_valid = 0; rsp_data = 0; redirect = 0;
    redirect_pc = 0; instr_ready = 0;
    rst2_n = 0; ready2 = 0; rsp2_valid = 0; rsp2_data = 0;
    mem_pend = 0; mem_fire = 0; mem_cnt = 0; mem_addr = 0; spurious_en = 0;
    lat_lo = 0; lat_hi = 0; last_hs = 0;
    model_reset();

    // ---- wrapping reset PC and mid-WAIT reset on the second instance ----
    repeat (2) @(posedge clk);
    #1 rst2_n = 1;
    chk("w2_reset_addr", w2_req_addr, 32'hFFFF_FFFC);
    chk("w2_reset_valid", {31'b0, w2_req_valid}, 32'd0);
    @(posedge clk); #1;
    chk("w2_first_valid", {31'b0, w2_req_valid}, 32'd1);
    ready2 = 1;
    @(posedge clk); #1; ready2 = 0;
    chk("w2_wrap_addr", w2_req_addr, 32'h0);
    chk("w2_wait_valid", {31'b0, w2_req_valid}, 32'd0);
    rsp2_valid = 1; rsp2_data = 32'h0050_0093;
    @(posedge clk); #1; rsp2_valid = 0;
    chk("w2_head_valid", {31'b0, w2_instr_valid}, 32'd1);
    chk("w2_head_pc", w2_pc, 32'hFFFF_FFFC);
    chk("w2_head_pc4", w2_pc4, 32'h0);
    chk("w2_head_op", {25'b0, w2_op}, 32'h13);
    ready2 = 1;
    @(posedge clk); #1; ready2 = 0;
    chk("w2_second_out", {31'b0, w2_req_valid}, 32'd0);
    #2 rst2_n = 0;
    #1;
    chk("w2_async_addr", w2_req_addr, 32'hFFFF_FFFC);
    chk("w2_async_ivalid", {31'b0, w2_instr_valid}, 32'd0);
    chk("w2_async_rvalid", {31'b0, w2_req_valid}, 32'd0);
    @(posedge clk); #1 rst2_n = 1; rsp2_valid = 1; rsp2_data = 32'hDEAD_BEEF;
    @(posedge clk); #1 rsp2_valid = 0;
    chk("w2_late_rsp_ignored", {31'b0, w2_instr_valid}, 32'd0);
    @(posedge clk); #1;
    chk("w2_restart_valid", {31'b0, w2_req_valid}, 32'd1);
    chk("w2_restart_addr", w2_req_addr, 32'hFFFF_FFFC);
    chk("w2_still_empty", {31'b0, w2_instr_valid}, 32'd0);

    // ---- main instance: reset state, then basic fetch (1-cycle rsp) ----
    drive(1, 1, 0, 32'h0);
    rst_n = 1;
    repeat (3) drive(1, 1, 0, 32'h0);
    chk("t1_instr_valid", {31'b0, instr_valid}, 32'd1);
    chk("t1_instr_pc", instr_pc, 32'h0);
    chk("t1_op", {25'b0, op}, 32'h13);
    chk("t1_funct3", {29'b0, funct3}, 32'd0);
    chk("t1_next_addr", req_addr, 32'h4);

    // ---- decode stalls: buffer fills, requests stop, then drains in order ----
    repeat (10) drive(1, 0, 0, 32'h0);
    chk("t2_req_blocked", {31'b0, req_valid}, 32'd0);
    chk("t2_head_pc", instr_pc, 32'h0);
    drive(1, 1, 0, 32'h0);
    chk("t2_drain_pc", instr_pc, 32'h4);

    // ---- redirect while a request is outstanding ----
    lat_lo = 2; lat_hi = 2;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(1, 1, 0, 32'h0);
      found = last_hs;
    end
    chk("t3_hs_seen", {31'b0, found}, 32'd1);
    drive(1, 1, 1, 32'h100);
    chk("t3_target_addr", req_addr, 32'h100);
    chk("t3_flushed", {31'b0, instr_valid}, 32'd0);
    repeat (12) drive(1, 1, 0, 32'h0);

    // ---- redirect coinciding with a response and a pop ----
    lat_lo = 0; lat_hi = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      found = mem_pend && (mem_cnt == 0) && (m_fifo.size() > 0);
      if (!found) drive(1, 0, 0, 32'h0);
    end
    chk("t4_setup_seen", {31'b0, found}, 32'd1);
    drive(1, 1, 1, 32'h200);
    chk("t4_empty", {31'b0, instr_valid}, 32'd0);
    repeat (8) drive(1, 1, 0, 32'h0);

    // ---- misaligned target ----
    drive(1, 1, 1, 32'h102);
    chk("t5_misalign", {31'b0, misalign}, 32'd1);
    chk("t5_addr", req_addr, 32'h100);
    drive(1, 1, 0, 32'h0);
    chk("t5_pulse_end", {31'b0, misalign}, 32'd0);
    repeat (6) drive(1, 1, 0, 32'h0);

    // ---- PC wrap through a redirect ----
    drive(1, 1, 1, 32'hFFFF_FFFC);
    repeat (8) drive(1, 1, 0, 32'h0);

    // ---- randomized phase ----
    lat_lo = 0; lat_hi = 3; spurious_en = 1; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (rst_n == 0) rst_n = 1;
      else if ($urandom_range(0, 199) == 0) begin
        rst_n = 0; model_reset(); hold = 6;
      end
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      drive((hold == 0) && ($urandom_range(0, 3) != 0),
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 15) == 0, rpc);
      if (hold > 0) hold--;
    end
    rst_n = 1;
    drive(0, 1, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
